// File: rtl/risc_pkg.sv
// Shared definitions for the risc core and its self-checking trace monitor.
package risc_pkg;

  localparam int RISC_DATA_W = 16;
  localparam int RISC_FLAG_W = 3;

  typedef enum logic [1:0] {
    CHK_IDLE = 2'd0,
    CHK_RUN  = 2'd1,
    CHK_DONE = 2'd2
  } chk_state_t;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port (read-old-data).
module trace_ram #(
  parameter  int WIDTH = 19,
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rdata_r;

  // write port; contents survive reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // registered read port, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r <= '0;
    end else begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/risc_trace_checker.sv
// Compares retired ALU results against a preloaded expected table, logs them to a trace
// buffer and reports DONE/PASS after a programmed number of checks or a cycle limit.
module risc_trace_checker
  import risc_pkg::*;
#(
  parameter  int DATA_W      = RISC_DATA_W,
  parameter  int FLAG_W      = RISC_FLAG_W,
  parameter  int DEPTH       = 32,
  parameter  int CYCLE_LIMIT = 40,
  localparam int AW          = $clog2(DEPTH),
  localparam int TW          = $clog2(CYCLE_LIMIT + 1),
  localparam int EW          = DATA_W + FLAG_W,
  localparam int NW          = AW + 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              VALID_IN,
  input  logic [DATA_W-1:0] ALU_RES,
  input  logic [FLAG_W-1:0] STATUS_FLAG,
  input  logic              EXP_WE,
  input  logic [AW-1:0]     EXP_ADDR,
  input  logic [EW-1:0]     EXP_DATA,
  input  logic [NW-1:0]     NUM_CHECKS,
  input  logic              START,
  input  logic [AW-1:0]     RD_ADDR,
  output logic [EW:0]       RD_DATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic              TIMEOUT,
  output logic [NW-1:0]     MISMATCH_CNT,
  output logic [AW-1:0]     FIRST_FAIL
);

  chk_state_t    state_r;
  logic [AW-1:0] idx_r;
  logic [TW-1:0] cyc_r;
  logic [NW-1:0] num_r;
  logic [NW-1:0] cnt_r;
  logic [AW-1:0] ff_r;
  logic          to_r;
  logic          busy_r;
  logic          done_r;
  logic          pass_r;

  logic [EW-1:0] sample_s;
  logic [EW-1:0] exp_q_s;
  logic [AW-1:0] exp_raddr_s;
  logic          exp_we_s;
  logic          accept_s;
  logic          miss_s;
  logic          final_s;
  logic          limit_s;
  logic [NW-1:0] cnt_next_s;

  assign sample_s   = {STATUS_FLAG, ALU_RES};
  assign accept_s   = (state_r == CHK_RUN) && VALID_IN;
  assign miss_s     = (sample_s != exp_q_s);
  assign final_s    = accept_s && ({1'b0, idx_r} == (num_r - NW'(1)));
  assign limit_s    = (cyc_r == TW'(CYCLE_LIMIT - 1));
  assign exp_we_s   = EXP_WE && (state_r == CHK_IDLE);
  assign cnt_next_s = (cnt_r == {NW{1'b1}}) ? cnt_r : (cnt_r + NW'(1));

  // pre-fetch address so exp_q_s always holds expected[idx] during RUN
  always_comb begin
    exp_raddr_s = '0;
    if (accept_s) begin
      exp_raddr_s = idx_r + AW'(1);
    end else if (state_r == CHK_RUN) begin
      exp_raddr_s = idx_r;
    end else begin
      exp_raddr_s = '0;
    end
  end

  trace_ram #(.WIDTH(EW), .DEPTH(DEPTH)) u_exp_ram (
    .clk   (CLK),
    .rst   (RESET),
    .we    (exp_we_s),
    .waddr (EXP_ADDR),
    .wdata (EXP_DATA),
    .raddr (exp_raddr_s),
    .rdata (exp_q_s)
  );

  trace_ram #(.WIDTH(EW + 1), .DEPTH(DEPTH)) u_trace_ram (
    .clk   (CLK),
    .rst   (RESET),
    .we    (accept_s),
    .waddr (idx_r),
    .wdata ({miss_s, sample_s}),
    .raddr (RD_ADDR),
    .rdata (RD_DATA)
  );

  // check-run FSM with registered status outputs; final sample beats the cycle limit
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= CHK_IDLE;
      idx_r   <= '0;
      cyc_r   <= '0;
      num_r   <= '0;
      cnt_r   <= '0;
      ff_r    <= '0;
      to_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
    end else begin
      case (state_r)
        CHK_IDLE, CHK_DONE: begin
          if (START) begin
            num_r   <= (NUM_CHECKS == '0) ? NW'(DEPTH) : NUM_CHECKS;
            idx_r   <= '0;
            cyc_r   <= '0;
            cnt_r   <= '0;
            ff_r    <= '0;
            to_r    <= 1'b0;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
            state_r <= CHK_RUN;
          end
        end
        CHK_RUN: begin
          cyc_r <= cyc_r + TW'(1);
          if (accept_s) begin
            idx_r <= idx_r + AW'(1);
            if (miss_s) begin
              cnt_r <= cnt_next_s;
              if (cnt_r == '0) begin
                ff_r <= idx_r;
              end
            end
          end
          if (final_s) begin
            state_r <= CHK_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            pass_r  <= (cnt_r == '0) && !miss_s;
          end else if (limit_s) begin
            state_r <= CHK_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            to_r    <= 1'b1;
            pass_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= CHK_IDLE;
        end
      endcase
    end
  end

  assign BUSY         = busy_r;
  assign DONE         = done_r;
  assign PASS         = pass_r;
  assign TIMEOUT      = to_r;
  assign MISMATCH_CNT = cnt_r;
  assign FIRST_FAIL   = ff_r;

endmodule

// File: tb/tb_risc_trace_checker.sv
// Self-checking bench for risc_trace_checker: table-driven runs, corner sequences, random runs.
module tb_risc_trace_checker;

  localparam int DW    = 16;
  localparam int FW    = 3;
  localparam int DEPTH = 32;
  localparam int LIM   = 40;
  localparam int AW    = 5;
  localparam int EW    = DW + FW;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          VALID_IN = 1'b0;
  logic [DW-1:0] ALU_RES = '0;
  logic [FW-1:0] STATUS_FLAG = '0;
  logic          EXP_WE = 1'b0;
  logic [AW-1:0] EXP_ADDR = '0;
  logic [EW-1:0] EXP_DATA = '0;
  logic [AW:0]   NUM_CHECKS = '0;
  logic          START = 1'b0;
  logic [AW-1:0] RD_ADDR = '0;
  logic [EW:0]   RD_DATA;
  logic          BUSY, DONE, PASS, TIMEOUT;
  logic [AW:0]   MISMATCH_CNT;
  logic [AW-1:0] FIRST_FAIL;

  always #5 CLK = ~CLK;

  risc_trace_checker #(.DATA_W(DW), .FLAG_W(FW), .DEPTH(DEPTH), .CYCLE_LIMIT(LIM)) dut (
    .CLK(CLK), .RESET(RESET), .VALID_IN(VALID_IN), .ALU_RES(ALU_RES),
    .STATUS_FLAG(STATUS_FLAG), .EXP_WE(EXP_WE), .EXP_ADDR(EXP_ADDR),
    .EXP_DATA(EXP_DATA), .NUM_CHECKS(NUM_CHECKS), .START(START),
    .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .BUSY(BUSY), .DONE(DONE),
    .PASS(PASS), .TIMEOUT(TIMEOUT), .MISMATCH_CNT(MISMATCH_CNT),
    .FIRST_FAIL(FIRST_FAIL)
  );

  typedef struct {
    bit          v;
    logic [DW-1:0] r;
    logic [FW-1:0] f;
    bit          st;
    bit          we;
  } samp_t;

  typedef struct {
    int          numv;
    int          nvalid;
    int          lead;
    int          gapmode;
    logic [31:0] mask;
    bit          inject;
    int          e_cyc;
    bit          e_to;
    int          e_cnt;
    int          e_ff;
    bit          e_pass;
  } vec_t;

  samp_t         q[$];
  logic [EW-1:0] exp_m   [DEPTH];
  logic [EW:0]   trace_m [DEPTH];
  int            m_cyc, m_k, m_cnt, m_ff;
  bit            m_to, m_pass;
  int            n_cmp = 0;
  int            n_bad = 0;
  vec_t          tbl[10];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic load(input int a, input logic [EW-1:0] d);
    EXP_WE = 1'b1; EXP_ADDR = AW'(a); EXP_DATA = d;
    tick();
    EXP_WE = 1'b0;
  endtask

  // Run outcome from the rules: samples consumed in order, cycle c sampled by edge c.
  task automatic model(input int num);
    int  k;
    bit  fin;
    logic miss;
    k = 0; fin = 1'b0; m_cnt = 0; m_ff = 0; m_to = 1'b0; m_cyc = LIM;
    for (int c = 1; c <= LIM && !fin; c++) begin
      if (c <= q.size() && q[c-1].v) begin
        miss = ({q[c-1].f, q[c-1].r} != exp_m[k]);
        trace_m[k] = {miss, q[c-1].f, q[c-1].r};
        if (miss) begin
          if (m_cnt == 0) m_ff = k;
          if (m_cnt < (2 ** (AW + 1)) - 1) m_cnt++;
        end
        if (k == num - 1) begin
          fin = 1'b1;
          m_cyc = c;
        end
        k++;
      end
      if (!fin && c == LIM) m_to = 1'b1;
    end
    m_k = k;
    m_pass = !m_to && (m_cnt == 0);
  endtask

  task automatic build(input int nvalid, input int lead, input int gapmode,
                       input logic [31:0] mask, input bit inject, input bit rnd_flip);
    samp_t         s;
    logic [EW-1:0] e;
    q.delete();
    s = '{default: 0};
    for (int i = 0; i < lead; i++) q.push_back(s);
    for (int v = 0; v < nvalid; v++) begin
      s = '{default: 0};
      if (gapmode == 2 && $urandom_range(0, 3) == 0) q.push_back(s);
      e = exp_m[v % DEPTH];
      if (v < 32 && mask[v]) begin
        if (rnd_flip) e = e ^ (EW'(1) << $urandom_range(0, EW - 1));
        else e = e ^ EW'(1);
      end
      s.v = 1'b1; s.r = e[DW-1:0]; s.f = e[EW-1:DW];
      q.push_back(s);
      s = '{default: 0};
      if (gapmode == 1 && v % 4 == 3 && v != nvalid - 1) q.push_back(s);
    end
    if (inject) begin
      s = '{default: 0};
      while (q.size() < 2) q.push_back(s);
      q[1].st = 1'b1;
      q[1].we = 1'b1;
    end
  endtask

  task automatic run(input int numv, output int cyc_o, output bit seen);
    samp_t s;
    NUM_CHECKS = (AW+1)'(numv); START = 1'b1;
    tick();
    START = 1'b0; NUM_CHECKS = ~NUM_CHECKS;
    seen = 1'b0; cyc_o = 0;
    while (!seen && cyc_o < LIM + 4) begin
      s = '{default: 0};
      if (cyc_o < q.size()) s = q[cyc_o];
      cyc_o++;
      VALID_IN = s.v; ALU_RES = s.r; STATUS_FLAG = s.f; START = s.st;
      EXP_WE = s.we; EXP_ADDR = AW'(1); EXP_DATA = ~exp_m[1];
      tick();
      seen = DONE;
    end
    VALID_IN = 1'b0; START = 1'b0; EXP_WE = 1'b0;
  endtask

  task automatic check_run(input string tag, input int cyc, input bit seen, input int e_cyc,
                           input bit e_to, input int e_cnt, input int e_ff, input bit e_pass);
    chk({tag, ".done"}, 64'(seen), 64'(1));
    chk({tag, ".cycles"}, 64'(cyc), 64'(e_cyc));
    chk({tag, ".busy"}, 64'(BUSY), 64'(0));
    chk({tag, ".timeout"}, 64'(TIMEOUT), 64'(e_to));
    chk({tag, ".mismatch_cnt"}, 64'(MISMATCH_CNT), 64'(e_cnt));
    chk({tag, ".first_fail"}, 64'(FIRST_FAIL), 64'(e_ff));
    chk({tag, ".pass"}, 64'(PASS), 64'(e_pass));
    for (int k = 0; k < m_k; k++) begin
      RD_ADDR = AW'(k);
      tick();
      chk($sformatf("%s.trace%0d", tag, k), 64'(RD_DATA), 64'(trace_m[k]));
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".busy"}, 64'(BUSY), 64'(0));
    chk({tag, ".done"}, 64'(DONE), 64'(0));
    chk({tag, ".pass"}, 64'(PASS), 64'(0));
    chk({tag, ".timeout"}, 64'(TIMEOUT), 64'(0));
    chk({tag, ".mismatch_cnt"}, 64'(MISMATCH_CNT), 64'(0));
    chk({tag, ".first_fail"}, 64'(FIRST_FAIL), 64'(0));
    chk({tag, ".rd_data"}, 64'(RD_DATA), 64'(0));
  endtask

  initial begin
    int cyc, numv, ne;
    bit seen;

    //          numv nval lead gap mask          inj  cyc to cnt ff pass
    tbl[0] = '{4,   4,   0,   0,  32'h0,        1'b0, 4,  1'b0, 0,  0, 1'b1};
    tbl[1] = '{4,   4,   0,   0,  32'h4,        1'b0, 4,  1'b0, 1,  2, 1'b0};
    tbl[2] = '{8,   3,   0,   0,  32'h0,        1'b0, 40, 1'b1, 0,  0, 1'b0};
    tbl[3] = '{4,   4,   0,   0,  32'h0,        1'b1, 4,  1'b0, 0,  0, 1'b1};
    tbl[4] = '{4,   4,   0,   0,  32'h0,        1'b0, 4,  1'b0, 0,  0, 1'b1};
    tbl[5] = '{0,   32,  0,   0,  32'hFFFFFFFF, 1'b0, 32, 1'b0, 32, 0, 1'b0};
    tbl[6] = '{0,   32,  0,   1,  32'hFFFFFFFF, 1'b0, 39, 1'b0, 32, 0, 1'b0};
    tbl[7] = '{8,   8,   32,  0,  32'h0,        1'b0, 40, 1'b0, 0,  0, 1'b1};
    tbl[8] = '{8,   8,   33,  0,  32'h0,        1'b0, 40, 1'b1, 0,  0, 1'b0};
    tbl[9] = '{10,  10,  0,   0,  32'h120,      1'b0, 10, 1'b0, 2,  5, 1'b0};

    RESET = 1'b1;
    tick(); tick();
    check_zero("reset");
    RESET = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      exp_m[i] = {FW'(i) ^ 3'b101, 16'h00FC + DW'(i)};
      load(i, exp_m[i]);
    end

    for (int i = 0; i < 10; i++) begin
      ne = (tbl[i].numv == 0) ? DEPTH : tbl[i].numv;
      build(tbl[i].nvalid, tbl[i].lead, tbl[i].gapmode, tbl[i].mask, tbl[i].inject, 1'b0);
      model(ne);
      run(tbl[i].numv, cyc, seen);
      check_run($sformatf("vec%0d", i), cyc, seen, tbl[i].e_cyc, tbl[i].e_to,
                tbl[i].e_cnt, tbl[i].e_ff, tbl[i].e_pass);
      if (i == 1) begin
        RD_ADDR = AW'(2);
        tick();
        chk("vec1.trace2_literal", 64'(RD_DATA), 64'({1'b1, 3'b111, 16'h00FF}));
      end
    end

    // DONE holds results: VALID_IN and EXP_WE are ignored here
    for (int i = 0; i < 3; i++) begin
      VALID_IN = 1'b1; ALU_RES = DW'($urandom); STATUS_FLAG = FW'($urandom);
      EXP_WE = 1'b1; EXP_ADDR = '0; EXP_DATA = ~exp_m[0];
      tick();
    end
    VALID_IN = 1'b0; EXP_WE = 1'b0;
    chk("done_hold.done", 64'(DONE), 64'(1));
    chk("done_hold.mismatch_cnt", 64'(MISMATCH_CNT), 64'(tbl[9].e_cnt));
    chk("done_hold.first_fail", 64'(FIRST_FAIL), 64'(tbl[9].e_ff));

    // reset in the middle of a run, then a clean rerun on the retained table
    NUM_CHECKS = 6'd4; START = 1'b1;
    tick();
    START = 1'b0;
    for (int v = 0; v < 2; v++) begin
      VALID_IN = 1'b1; ALU_RES = exp_m[v][DW-1:0]; STATUS_FLAG = exp_m[v][EW-1:DW] ^ 3'b001;
      tick();
    end
    VALID_IN = 1'b0;
    chk("midrun.busy", 64'(BUSY), 64'(1));
    chk("midrun.mismatch_cnt", 64'(MISMATCH_CNT), 64'(2));
    RESET = 1'b1;
    tick();
    check_zero("midrun_reset");
    RESET = 1'b0;
    build(4, 0, 0, 32'h0, 1'b0, 1'b0);
    model(4);
    run(4, cyc, seen);
    check_run("after_reset", cyc, seen, 4, 1'b0, 0, 0, 1'b1);

    for (int it = 0; it < 25; it++) begin
      if (it % 5 == 0) begin
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
          exp_m[i] = EW'($urandom);
          load(i, exp_m[i]);
        end
      end
      numv = $urandom_range(0, DEPTH - 1);
      ne = (numv == 0) ? DEPTH : numv;
      build($urandom_range(0, ne + 2), $urandom_range(0, 4), $urandom_range(0, 2),
            $urandom & $urandom & $urandom, 1'($urandom_range(0, 1)), 1'b1);
      model(ne);
      run(numv, cyc, seen);
      check_run($sformatf("rnd%0d", it), cyc, seen, m_cyc, m_to, m_cnt, m_ff, m_pass);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/risc_trace_checker.md
# risc_trace_checker

Parametrised, synthesizable self-checking monitor for the `risc` core. It replaces the open-loop bench's fixed 40-edge run with automated result checking. Each retired ALU result and its status flags are compared against a preloaded expected table and recorded in a trace buffer. The block counts mismatches and raises `DONE`/`PASS` when a programmed number of results has been checked or a cycle limit expires. It sits beside the core, on `ALU_RES`/`STATUS_FLAG`, in both simulation and FPGA bring-up builds.

## Interface
Parameters:
- `DATA_W`, 16, ALU result width
- `FLAG_W`, 3, status flag width
- `DEPTH`, 32, number of expected/trace entries; power of two; `AW = $clog2(DEPTH)`
- `CYCLE_LIMIT`, 40, maximum RUN cycles before timeout; `TW = $clog2(CYCLE_LIMIT+1)`

Ports:
- `CLK`  in  1  rising-edge clock
- `RESET`  in  1  synchronous, active-high reset
- `VALID_IN`  in  1  `ALU_RES`/`STATUS_FLAG` hold a retired result this cycle
- `ALU_RES`  in  DATA_W  result from the core
- `STATUS_FLAG`  in  FLAG_W  flags from the core
- `EXP_WE`  in  1  expected-table write strobe
- `EXP_ADDR`  in  AW  expected-table write address
- `EXP_DATA`  in  DATA_W+FLAG_W  expected entry, `{flags, result}`
- `NUM_CHECKS`  in  AW+1  number of results to check, 1..DEPTH; sampled on START
- `START`  in  1  begin a check run
- `RD_ADDR`  in  AW  trace read address
- `RD_DATA`  out  DATA_W+FLAG_W+1  `{mismatch, flags, result}` of the trace entry
- `BUSY`  out  1  high in RUN
- `DONE`  out  1  high in DONE
- `PASS`  out  1  valid while DONE: no mismatch and no timeout
- `TIMEOUT`  out  1  run ended by the cycle limit
- `MISMATCH_CNT`  out  AW+1  saturating mismatch count
- `FIRST_FAIL`  out  AW  index of the first mismatch; 0 if none

## Operation
- FSM states are IDLE, RUN and DONE. Reset sends the FSM to IDLE.
- **IDLE.** `EXP_WE` writes the expected table. When `START` is asserted:
  - latch `NUM_CHECKS`; 0 is treated as DEPTH;
  - clear `idx`, the cycle counter, `MISMATCH_CNT`, `FIRST_FAIL` and `TIMEOUT`;
  - move to RUN.
- **RUN.** On each cycle with `VALID_IN`:
  - compare `{STATUS_FLAG, ALU_RES}` with `expected[idx]`;
  - write `{miss, STATUS_FLAG, ALU_RES}` to `trace[idx]`;
  - on a mismatch, increment `MISMATCH_CNT`, saturating at all-ones;
  - on the first mismatch only, latch `FIRST_FAIL = idx`;
  - increment `idx`.
- **RUN cycle counter.** It increments every RUN cycle. RUN exits to DONE on either of these conditions:
  - the valid sample at `idx == NUM_CHECKS-1`;
  - the counter reaching `CYCLE_LIMIT-1` with no such sample, which also sets `TIMEOUT`.
- **Simultaneous events.** If the final sample and the cycle limit coincide, the final sample wins and `TIMEOUT` stays 0.
- **DONE.** Hold all results. `START` returns to RUN with the same clearing as from IDLE.
- **Ignored inputs.**
  - `EXP_WE` is ignored in RUN and DONE.
  - `START` is ignored in RUN.
  - `VALID_IN` is ignored outside RUN.
- **Formula.** `PASS = DONE & ~TIMEOUT & (MISMATCH_CNT == 0)`.

## Timing
- **Reset values.** Asserting `RESET` on any edge produces these values, including mid-run:
  - `BUSY`, `DONE`, `PASS`, `TIMEOUT`, `MISMATCH_CNT`, `FIRST_FAIL` = 0;
  - state = IDLE;
  - the `RD_DATA` register = 0.
  
  Memory contents are not cleared.
- **Status flags.** The RUN→DONE transition happens on the edge that samples the final `VALID_IN`. `BUSY` falls and `DONE` rises on that same edge. The final compare is already reflected in `MISMATCH_CNT` and `PASS`.
- **Memory ports.** Trace and expected writes are synchronous. `RD_DATA` is registered with 1-cycle latency and is readable in any state. A read of the address being written in the same cycle returns the old data.
- **Timeout.** `TIMEOUT` rises together with `DONE`, on the edge that ends cycle number `CYCLE_LIMIT` of RUN.
- **Back-to-back valids.** One result per cycle is accepted and there are no stall cycles.

## Structure
- Shared package `risc_pkg` holds:
  - the `chk_state_t` enum (IDLE, RUN, DONE);
  - default `DATA_W`/`FLAG_W` constants shared with `risc`.
- Sub-module `trace_ram`: a simple dual-port synchronous RAM with parameters WIDTH and DEPTH, one write port and one registered read port. It is instantiated twice:
  - expected table, read at `idx` combinationally-addressed and pre-fetched;
  - trace buffer, read at `RD_ADDR`.
- **Expected-table pre-fetch.** The compare uses an expected value that is already registered. `idx+1` is pre-fetched on each accept, and `expected[0]` is fetched in IDLE and DONE.

## Test plan
- **All match.** Load 4 entries, `NUM_CHECKS=4`, START, drive 4 matching valids back-to-back → `DONE` after the 4th edge, `PASS=1`, `MISMATCH_CNT=0`.
- **Single mismatch.** Same setup, but the 3rd result is `16'h00FF` against an expected `16'h00FE` → `MISMATCH_CNT=1`, `FIRST_FAIL=2`, `PASS=0`. Reading trace[2] returns `{1,flags,16'h00FF}` one cycle after `RD_ADDR=2`.
- **Timeout.** `NUM_CHECKS=8`, only 3 valids, `CYCLE_LIMIT=40` → `TIMEOUT=1` and `DONE` exactly 40 cycles after START, `PASS=0`.
- **Reset mid-run.** `RESET` after 2 valids → all outputs 0 and state IDLE next cycle. A new START then runs cleanly using the retained expected table.
- **Saturation and full depth.** `DEPTH=4`, `NUM_CHECKS=0` (treated as 4), all 4 mismatched → `MISMATCH_CNT=4`, `FIRST_FAIL=0`. With gaps in `VALID_IN`, the results are unchanged.
- **Ignored inputs.** `EXP_WE` during RUN and `START` during RUN → no effect on the table or on the counters.
